// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem read port, and a
// 2-entry {instr, pc} buffer feeding decode, with redirect flush of buffered/in-flight words.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t [1:0]  r_ent;
   logic        r_head;
   logic [1:0]  r_count;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic        r_outstanding;
   logic        r_drop;

   logic        w_req_fire;
   logic        w_rsp_take;
   logic        w_push;
   logic        w_pop;
   logic        w_tail;
   logic [31:0] w_redir_pc;
   ent_t        w_head_ent;

   // A request is only issued when a buffer slot is guaranteed for its response.
   assign imem_req_valid = !reset && !r_outstanding && (r_count != 2'd2) && !redirect_valid;
   assign imem_addr      = r_pc;

   assign w_req_fire = imem_req_valid && imem_req_ready;
   assign w_rsp_take = imem_rsp_valid && r_outstanding;
   assign w_push     = w_rsp_take && !r_drop && !redirect_valid;
   assign w_pop      = id_valid && id_ready && !redirect_valid;
   assign w_tail     = r_head ^ r_count[0];
   assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

   assign w_head_ent  = r_ent[r_head];
   assign id_valid    = !reset && (r_count != 2'd0);
   assign id_instr    = w_head_ent.instr;
   assign id_pc       = w_head_ent.pc;
   assign id_pc_plus4 = w_head_ent.pc + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= RESET_PC;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
         r_count       <= 2'd0;
         r_head        <= 1'b0;
         r_ent         <= '0;
      end else begin
         if (w_rsp_take) begin
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
         end
         if (w_req_fire) begin
            r_req_pc      <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_outstanding <= 1'b1;
         end
         if (w_push)
            r_ent[w_tail] <= '{instr: imem_rsp_data, pc: r_req_pc};
         if (redirect_valid) begin
            r_pc    <= w_redir_pc;
            r_count <= 2'd0;
            // Response still in flight belongs to the old path; swallow it on arrival.
            if (r_outstanding && !w_rsp_take)
               r_drop <= 1'b1;
         end else begin
            if (w_pop)
               r_head <= ~r_head;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the main flows plus hand sequences
// for wrap-around reset PC and reset asserted with a fetch in flight.
module tb_instr_fetch;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;

   logic        req_valid,  req_valid2;
   logic [31:0] addr,       addr2;
   logic        idv,        idv2;
   logic [31:0] instr,      instr2;
   logic [31:0] pc,         pc2;
   logic [31:0] pc4,        pc42;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_addr(addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(idv), .id_ready(id_ready), .id_instr(instr), .id_pc(pc), .id_pc_plus4(pc4)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
      .clk(clk), .reset(reset),
      .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_addr(addr2),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(idv2), .id_ready(id_ready), .id_instr(instr2), .id_pc(pc2), .id_pc_plus4(pc42)
   );

   typedef struct {
      logic        redir;
      logic [31:0] rdpc;
      logic        idr;
      logic        reqr;
      logic        hold;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_idv;
      logic [31:0] e_pc;
   } vec_t;

   vec_t        vecs[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;

   task automatic addv(input logic redir, input logic [31:0] rdpc, input logic idr, reqr, hold,
                       input logic e_req, input logic [31:0] e_addr, input logic e_idv,
                       input logic [31:0] e_pc);
      vec_t v;
      v.redir = redir; v.rdpc = rdpc; v.idr = idr; v.reqr = reqr; v.hold = hold;
      v.e_req = e_req; v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   // Memory model: one word in flight, returned addr^K the cycle after accept unless held.
   task automatic drive(input logic rst, rdv, input logic [31:0] rdp, input logic idr, rqr, hld);
      reset          = rst;
      redirect_valid = rdv;
      redirect_pc    = rdp;
      id_ready       = idr;
      imem_req_ready = rqr;
      imem_rsp_valid = pend && !hld;
      imem_rsp_data  = pend_addr ^ K;
      #1;
   endtask

   task automatic step();
      logic        acc, dlv;
      logic [31:0] a;
      acc = req_valid && imem_req_ready;
      dlv = imem_rsp_valid;
      a   = addr;
      @(posedge clk);
      #1;
      if (dlv) pend = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_addr = a;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic normal();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      pend = 1'b0;
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
      chk("rst_id_valid", {31'b0, idv}, 32'd0);
      step();
   endtask

   initial begin
      logic [129:0] got, exp;
      normal();
      do_reset();

      // Reset state visible on the first cycle out of reset
      normal();
      chk("rst_id_instr", instr, 32'h0);
      chk("rst_id_pc", pc, 32'h0);
      chk("rst_id_pc_plus4", pc4, 32'h4);
      chk("rst_id_valid_after", {31'b0, idv}, 32'd0);

      // Steady-state 1-cycle memory
      addv(0, 0, 1, 1, 0,  1, 32'h00, 0, 0);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h04, 1, 32'h00);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h08, 1, 32'h04);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h0C, 1, 32'h08);
      // Decode stalls: buffer fills to 2, requests stop, head holds
      addv(0, 0, 0, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 0, 1, 0,  1, 32'h10, 1, 32'h0C);
      addv(0, 0, 0, 1, 0,  0, 0,      1, 32'h0C);
      addv(0, 0, 0, 1, 0,  0, 0,      1, 32'h0C);
      addv(0, 0, 0, 1, 0,  0, 0,      1, 32'h0C);
      addv(0, 0, 0, 1, 0,  0, 0,      1, 32'h0C);
      addv(0, 0, 1, 1, 0,  0, 0,      1, 32'h0C);
      addv(0, 0, 1, 1, 0,  1, 32'h14, 1, 32'h10);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h18, 1, 32'h14);
      // Memory not ready: request held with stable address
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 0, 0,  1, 32'h1C, 1, 32'h18);
      addv(0, 0, 1, 0, 0,  1, 32'h1C, 0, 0);
      addv(0, 0, 1, 0, 0,  1, 32'h1C, 0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h1C, 0, 0);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h20, 1, 32'h1C);
      // Redirect with one buffered and one in flight (response delayed)
      addv(0, 0, 0, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 0, 1, 0,  1, 32'h24, 1, 32'h20);
      addv(0, 0, 0, 1, 1,  0, 0,      1, 32'h20);
      addv(1, 32'h102, 0, 1, 1,  0, 0, 1, 32'h20);
      addv(0, 0, 0, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 0, 1, 0,  1, 32'h100, 0, 0);
      addv(0, 0, 0, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h104, 1, 32'h100);
      // Redirect coinciding with the response
      addv(1, 32'h200, 1, 1, 0,  0, 0, 0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h200, 0, 0);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);
      addv(0, 0, 1, 1, 0,  1, 32'h204, 1, 32'h200);
      addv(0, 0, 1, 1, 0,  0, 0,      0, 0);

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].redir, vecs[i].rdpc, vecs[i].idr, vecs[i].reqr, vecs[i].hold);
         exp = {vecs[i].e_req, vecs[i].e_req ? vecs[i].e_addr : 32'h0, vecs[i].e_idv,
                vecs[i].e_idv ? {vecs[i].e_pc, vecs[i].e_pc ^ K, vecs[i].e_pc + 32'd4} : 96'h0};
         got = {req_valid, vecs[i].e_req ? addr : 32'h0, idv,
                vecs[i].e_idv ? {pc, instr, pc4} : 96'h0};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL vec%0d {req,addr,idv,pc,instr,pc4}: got %h, expected %h", i, got, exp);
         end
         step();
      end

      // Wrapping reset PC on the second instance
      do_reset();
      normal();
      chk("wrap_addr0", {req_valid2, addr2[30:0]}, {1'b1, 31'h7FFF_FFF8});
      chk("wrap_addr0_hi", {31'b0, addr2[31]}, 32'd1);
      step(); normal(); step(); normal();
      chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
      chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
      chk("wrap_pc0_plus4", pc42, 32'hFFFF_FFFC);
      step(); normal(); step(); normal();
      chk("wrap_addr2", addr2, 32'h0000_0000);
      chk("wrap_idv", {31'b0, idv2}, 32'd1);
      chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
      chk("wrap_pc1_plus4", pc42, 32'h0000_0000);
      step();

      // Reset while a fetch is in flight; the late response must be ignored
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_req_valid", {30'b0, req_valid, req_valid2}, 32'd0);
      chk("mid_rst_id_valid", {30'b0, idv, idv2}, 32'd0);
      step();
      normal();
      chk("post_rst_id_valid", {30'b0, idv, idv2}, 32'd0);
      chk("post_rst_req", {30'b0, req_valid, req_valid2}, 32'd3);
      chk("post_rst_addr", addr, 32'h0);
      chk("post_rst_addr2", addr2, 32'hFFFF_FFF8);
      step(); normal(); step(); normal();
      chk("post_rst_head_valid", {30'b0, idv, idv2}, 32'd3);
      chk("post_rst_head_pc", pc, 32'h0);
      chk("post_rst_head_instr", instr, K);
      chk("post_rst_head_pc2", pc2, 32'hFFFF_FFF8);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
